sync_fifo: RTL
==============

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits (>=1) SHALL apply to i_data and o_data.
REQ-002 Parameter DEPTH, default 16, storage depth in words SHALL be a power of two and >=2.
REQ-003 Parameter FWFT, default 0, read mode SHALL be 0 = registered read or 1 = first-word-fall-through.
REQ-004 Parameter AF_THRESH, default DEPTH-2, SHALL set the almost-full level: o_almost_full=1 when count >= AF_THRESH.
REQ-005 Parameter AE_THRESH, default 2, SHALL set the almost-empty level: o_almost_empty=1 when count <= AE_THRESH.
REQ-006 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 i_reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-008 i_data  input  DATA_W  SHALL carry the write data word.
REQ-009 i_write  input  1  SHALL be the write request.
REQ-010 i_read  input  1  SHALL be the read request.
REQ-011 i_clear_err  input  1  SHALL clear the sticky error flags.
REQ-012 o_data  output  DATA_W  SHALL carry the read data word.
REQ-013 o_valid  output  1  SHALL qualify o_data.
REQ-014 o_full / o_empty  output  1 each  SHALL be the full and empty flags.
REQ-015 o_almost_full / o_almost_empty  output  1 each  SHALL be the threshold flags.
REQ-016 o_count  output  $clog2(DEPTH)+1  SHALL give the stored word count, 0..DEPTH.
REQ-017 o_overflow / o_underflow  output  1 each  SHALL be the sticky error flags.

Function
REQ-018 Write SHALL be accepted iff i_write=1 and o_full=0; the word is stored at the write pointer, and the pointer increments modulo DEPTH.
REQ-019 Read SHALL be accepted iff i_read=1 and o_empty=0; the read pointer increments modulo DEPTH.
REQ-020 When full, a write SHALL be rejected even if a read is accepted in the same cycle.
REQ-021 When empty, a read SHALL be rejected even if a write is accepted in the same cycle.
REQ-022 Count SHALL update as: +1 on write only, -1 on read only, unchanged on both or neither; it never exceeds DEPTH or drops below 0.
REQ-023 All flags SHALL be registered and derived from next-count, so each flag is valid in the cycle its count is valid: o_full = (count==DEPTH), o_empty = (count==0).
REQ-024 FWFT=0: an accepted read SHALL load o_data with the head word on the next edge and pulse o_valid=1 for one cycle; o_data holds otherwise.
REQ-025 FWFT=1: o_data SHALL present the head word whenever o_empty=0, with o_valid = !o_empty.
REQ-026 FWFT=1: an accepted read SHALL pop the head word; the next word is presented the following cycle.
REQ-027 FWFT=1: a word written to an empty FIFO SHALL appear on o_data one cycle after the write edge.
REQ-028 o_overflow SHALL set on i_write=1 with o_full=1.
REQ-029 o_underflow SHALL set on i_read=1 with o_empty=1.
REQ-030 Both error flags SHALL be sticky until i_clear_err=1; if set and clear coincide, set SHALL win.
REQ-031 A rejected request SHALL alter no pointer, count, or storage.
REQ-032 Data order SHALL be strict FIFO across any number of pointer wraps.

Reset
REQ-033 While i_reset=1, asynchronously: pointers=0, count=0, o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0, o_valid=0, o_data=0, o_overflow=0, o_underflow=0.
REQ-034 Reset asserted mid-operation SHALL discard all stored words; storage contents need not be cleared.
REQ-035 The first write SHALL be accepted on the first rising edge after i_reset deasserts.

Verification (DATA_W=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1)
REQ-036 Reset, then write 0x11,0x22,0x33,0x44 -> o_count steps 1..4; o_almost_full=1 at count 3; o_full=1 at count 4; o_almost_empty=0 from count 2.
REQ-037 Full, then write 0x55 -> rejected, o_overflow=1, count stays 4; then i_clear_err -> o_overflow=0.
REQ-038 FWFT=0, full, then 4 reads -> o_data=0x11,0x22,0x33,0x44 each one cycle after its read, with an o_valid pulse; fifth read -> o_underflow=1, o_data holds 0x44.
REQ-039 Count 2, simultaneous read+write for 10 cycles with incrementing data -> count stays 2, outputs in order, pointers wrap with no loss.
REQ-040 FWFT=1, empty, then write 0xA5 -> next cycle o_valid=1, o_data=0xA5; read -> o_empty=1 next cycle.
REQ-041 Count 3, assert i_reset asynchronously mid-cycle -> flags reach reset values immediately; a post-reset write of 0x77 reads back 0x77.

Source files
------------

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered flags, sticky error flags and a registered-read or fall-through read port.
// Single-cycle write acceptance; registered read data one edge after the read is accepted.
module sync_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_write,
    input  logic                     i_read,
    input  logic                     i_clear_err,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_almost_full,
    output logic                     o_almost_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              af_q, af_d, ae_q, ae_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wr_acc, rd_acc;

    always_comb begin
        wr_acc   = i_write && !full_q;
        rd_acc   = i_read && !empty_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);

        // Set has priority over clear so an error in the clearing cycle is not lost.
        ovf_d = (i_write && full_q) || (ovf_q && !i_clear_err);
        udf_d = (i_read && empty_q) || (udf_q && !i_clear_err);

        valid_d = 1'b0;
        data_d  = data_q;
        if (FWFT != 0) begin
            // Pre-load the word that will be at the head after this edge; it may be the one being written.
            if (count_d != '0) begin
                data_d = (wr_acc && (rd_ptr_d == wr_ptr_q)) ? i_data : mem[rd_ptr_d];
            end
        end else begin
            valid_d = rd_acc;
            if (rd_acc) begin
                data_d = mem[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign o_data         = data_q;
    assign o_valid        = (FWFT != 0) ? !empty_q : valid_q;
    assign o_full         = full_q;
    assign o_empty        = empty_q;
    assign o_almost_full  = af_q;
    assign o_almost_empty = ae_q;
    assign o_count        = count_q;
    assign o_overflow     = ovf_q;
    assign o_underflow    = udf_q;

endmodule
